// File: rtl/alu_dispatcher.sv
// Request dispatcher for a multi-cycle ALU: 2-deep request FIFO, issue/wait FSM
// with finish timeout, and a single-entry response register with valid/ready handshake.
`timescale 1ns/1ps

module alu_dispatcher #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  output logic        start,
  output logic [1:0]  s,
  output logic [7:0]  opnd_x,
  output logic [7:0]  opnd_y,
  input  logic        finish,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a FIFO head and a free response slot; div-by-zero retired here
  // ISSUE | one-cycle start pulse to the control unit, timeout counter cleared
  // WAIT  | waiting for finish or for the timeout counter to expire
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] LP_OP_DIV   = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [17:0] r_fifo_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic [7:0]  r_wait_cnt;

  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [17:0] w_head;
  logic [1:0]  w_head_op;
  logic [7:0]  w_head_x;
  logic [7:0]  w_head_y;
  logic        w_head_div0;
  logic        w_slot_free;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_rsp_load;
  logic [15:0] w_rsp_load_data;
  logic        w_rsp_load_err;

  assign w_full    = (r_count == 2'd2);
  assign w_empty   = (r_count == 2'd0);
  assign w_push    = req_valid & ~w_full;
  assign req_ready = ~w_full;

  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign w_head_op   = w_head[17:16];
  assign w_head_x    = w_head[15:8];
  assign w_head_y    = w_head[7:0];
  assign w_head_div0 = (w_head_op == LP_OP_DIV) && (w_head_y == 8'd0);

  // A slot being drained this cycle counts as free so back-to-back responses need no bubble.
  assign w_slot_free = ~r_rsp_valid | rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= {req_op, req_x, req_y};
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_rsp_load      = 1'b0;
    w_rsp_load_data = 16'h0000;
    w_rsp_load_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && w_slot_free) begin
          if (w_head_div0) begin
            w_pop          = 1'b1;
            w_rsp_load     = 1'b1;
            w_rsp_load_err = 1'b1;
          end else begin
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (finish) begin
          w_pop           = 1'b1;
          w_rsp_load      = 1'b1;
          w_rsp_load_data = result;
          w_state_nxt     = IDLE;
        end else if (r_wait_cnt == LP_CNT_LAST) begin
          w_pop          = 1'b1;
          w_rsp_load     = 1'b1;
          w_rsp_load_err = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_wait_cnt <= 8'd0;
    end else if (w_cnt_clr) begin
      r_wait_cnt <= 8'd0;
    end else if (w_cnt_inc) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // A load in the same cycle as a handshake wins, keeping valid high with fresh data.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_err   <= 1'b0;
    end else if (w_rsp_load) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rsp_load_data;
      r_rsp_err   <= w_rsp_load_err;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign start     = (r_state == ISSUE);
  assign busy      = (r_state != IDLE);
  assign s         = w_empty ? 2'b00 : w_head_op;
  assign opnd_x    = w_empty ? 8'h00 : w_head_x;
  assign opnd_y    = w_empty ? 8'h00 : w_head_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_dispatcher.sv
// Scoreboard bench for alu_dispatcher: requests push expected responses, a control-unit
// responder plays the ALU, and a monitor pops and compares each accepted response.
`timescale 1ns/1ps

module tb_alu_dispatcher;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_x = 8'h00;
  logic [7:0]  req_y = 8'h00;
  logic        start;
  logic [1:0]  s;
  logic [7:0]  opnd_x;
  logic [7:0]  opnd_y;
  logic        finish;
  logic [15:0] result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  alu_dispatcher #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .start(start), .s(s), .opnd_x(opnd_x), .opnd_y(opnd_y),
    .finish(finish), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] lat;   // 0: never finish (timeout), 8'hFF: reset-test item, else finish in WAIT cycle lat
  } req_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  req_t iss_q[$];
  rsp_t exp_q[$];

  int   checks = 0;
  int   failures = 0;
  int   start_count = 0;
  int   start_cyc = 0;
  int   push_cyc = 0;
  logic rdy_mode = 1'b0;
  logic rdy_force = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'b00:   return 16'(x) + 16'(y);
      2'b01:   return 16'(x) - 16'(y);
      2'b10:   return 16'(x) * 16'(y);
      default: return {x % y, x / y};
    endcase
  endfunction

  task automatic push_req(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y, input logic [7:0] lat);
    req_t it;
    rsp_t ex;
    int   n;
    req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout: req_ready stuck at %0b, required 1", req_ready);
    end else begin
      push_cyc = cyc;
      it = '{op: op, x: x, y: y, lat: lat};
      if (op == 2'b11 && y == 8'h00) begin
        exp_q.push_back('{data: 16'h0000, err: 1'b1});
      end else begin
        iss_q.push_back(it);
        if (lat == 8'h00) begin
          exp_q.push_back('{data: 16'h0000, err: 1'b1});
        end else if (lat != 8'hFF) begin
          ex = '{data: alu_model(op, x, y), err: 1'b0};
          exp_q.push_back(ex);
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    rdy_mode = 1'b0; rdy_force = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(exp_q.size() == 0, name, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Downstream ready: either held at rdy_force or randomised every cycle.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      rsp_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: compares every accepted response and checks hold-under-backpressure.
  initial begin
    rsp_t        ex;
    logic        prev_hold;
    logic [15:0] prev_data;
    logic        prev_err;
    prev_hold = 1'b0; prev_data = 16'h0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && rsp_valid) begin
          chk({rsp_data, rsp_err} == {prev_data, prev_err}, "rsp_hold",
              32'({rsp_data, rsp_err}), 32'({prev_data, prev_err}));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: got data=%0h err=%0b, required no response", rsp_data, rsp_err);
          end else begin
            ex = exp_q.pop_front();
            chk(rsp_data == ex.data, "rsp_data", 32'(rsp_data), 32'(ex.data));
            chk(rsp_err == ex.err, "rsp_err", 32'(rsp_err), 32'(ex.err));
          end
        end
        prev_hold = rsp_valid && !rsp_ready;
        prev_data = rsp_data;
        prev_err  = rsp_err;
      end
    end
  end

  // Control-unit responder: checks the issued operation and drives finish/result.
  initial begin
    req_t cur;
    int   n;
    finish = 1'b0; result = 16'h0000;
    forever begin
      @(negedge clk);
      if (start) begin
        start_count++;
        start_cyc = cyc;
        if (iss_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start: start=1, required 0 with nothing queued");
        end else begin
          cur = iss_q.pop_front();
          chk({s, opnd_x, opnd_y} == {cur.op, cur.x, cur.y}, "issue_operands",
              32'({s, opnd_x, opnd_y}), 32'({cur.op, cur.x, cur.y}));
          @(negedge clk);
          chk(start == 1'b0, "start_one_cycle", 32'(start), 32'd0);
          chk(busy == 1'b1, "busy_in_wait", 32'(busy), 32'd1);
          if (cur.lat == 8'hFF) begin
            repeat (2) @(posedge clk);
            #1 finish = 1'b1; result = 16'hBEEF;
            @(posedge clk); #1 finish = 1'b0;
          end else if (cur.lat == 8'h00) begin
            n = 0;
            while (!rsp_valid && n < TO + 5) begin
              n++;
              @(negedge clk);
            end
            chk(rsp_valid && (cyc - start_cyc == TO + 1), "timeout_latency",
                32'(cyc - start_cyc), 32'(TO + 1));
          end else begin
            repeat (int'(cur.lat) - 1) @(negedge clk);
            chk({s, opnd_x, opnd_y} == {cur.op, cur.x, cur.y}, "operands_stable",
                32'({s, opnd_x, opnd_y}), 32'({cur.op, cur.x, cur.y}));
            finish = 1'b1;
            result = alu_model(cur.op, cur.x, cur.y);
            @(posedge clk); #1 finish = 1'b0;
            @(negedge clk);
            chk(rsp_valid == 1'b1, "finish_to_rsp", 32'(rsp_valid), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int   sc;
    int   n;
    logic p3_done;
    logic [1:0] op;
    logic [7:0] x, y, lat;
    p3_done = 1'b0;

    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk(start == 1'b0, "rst_start", 32'(start), 32'd0);
    chk({s, opnd_x, opnd_y} == 18'd0, "rst_operands", 32'({s, opnd_x, opnd_y}), 32'd0);
    chk(rsp_valid == 1'b0, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk({rsp_data, rsp_err} == 17'd0, "rst_rsp_data_err", 32'({rsp_data, rsp_err}), 32'd0);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
    chk(req_ready == 1'b1, "rst_req_ready", 32'(req_ready), 32'd1);

    // add with finish in the third WAIT cycle
    rdy_force = 1'b1;
    @(posedge clk); #1;
    sc = start_count;
    push_req(2'b00, 8'h12, 8'h34, 8'd3);
    drain("add_drain");
    chk(start_cyc - push_cyc == 2, "add_start_latency", 32'(start_cyc - push_cyc), 32'd2);
    chk(start_count - sc == 1, "add_start_count", 32'(start_count - sc), 32'd1);
    chk({s, opnd_x, opnd_y} == 18'd0, "idle_empty_operands", 32'({s, opnd_x, opnd_y}), 32'd0);

    // divide by zero never starts the control unit
    @(posedge clk); #1;
    sc = start_count;
    push_req(2'b11, 8'h50, 8'h00, 8'd1);
    drain("div0_drain");
    chk(start_count == sc, "div0_no_start", 32'(start_count - sc), 32'd0);

    // timeout on a mul, then a queued add still issues
    @(posedge clk); #1;
    sc = start_count;
    push_req(2'b10, 8'h0F, 8'h03, 8'd0);
    push_req(2'b00, 8'h01, 8'h02, 8'd2);
    drain("timeout_drain");
    chk(start_count - sc == 2, "timeout_next_issues", 32'(start_count - sc), 32'd2);

    // backpressure: three back-to-back pushes with the response slot blocked
    rdy_force = 1'b0;
    repeat (2) @(posedge clk); #1;
    sc = start_count;
    push_req(2'b00, 8'h21, 8'h43, 8'd2);
    push_req(2'b01, 8'h90, 8'h10, 8'd1);
    @(negedge clk);
    chk(req_ready == 1'b0, "full_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    fork
      begin
        push_req(2'b10, 8'h07, 8'h09, 8'd3);
        p3_done = 1'b1;
      end
    join_none
    n = 0;
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(rsp_valid == 1'b1, "bp_first_rsp", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk(start_count - sc == 1, "bp_second_held", 32'(start_count - sc), 32'd1);
    chk(busy == 1'b0, "bp_idle_while_blocked", 32'(busy), 32'd0);
    chk(req_ready == 1'b0, "bp_third_queued_full", 32'(req_ready), 32'd0);
    drain("bp_drain");
    chk(p3_done == 1'b1, "bp_third_accepted", 32'(p3_done), 32'd1);
    chk(start_count - sc == 3, "bp_all_issued", 32'(start_count - sc), 32'd3);

    // response slot drained in the same cycle a div-by-zero response loads
    rdy_force = 1'b0;
    repeat (2) @(posedge clk); #1;
    push_req(2'b00, 8'h33, 8'h44, 8'd1);
    push_req(2'b11, 8'h99, 8'h00, 8'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(rsp_valid == 1'b1, "simul_valid_stays", 32'(rsp_valid), 32'd1);
    chk({rsp_data, rsp_err} == {16'h0000, 1'b1}, "simul_new_data",
        32'({rsp_data, rsp_err}), 32'({16'h0000, 1'b1}));
    drain("simul_drain");

    // reset while waiting on the control unit
    @(posedge clk); #1;
    push_req(2'b10, 8'h05, 8'h06, 8'hFF);
    n = 0;
    while (!start && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(start == 1'b1, "rst_wait_started", 32'(start), 32'd1);
    @(posedge clk); #1 rst_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk({rsp_valid, busy} == 2'b00, "rst_mid_wait_quiet", 32'({rsp_valid, busy}), 32'd0);
    end
    chk(req_ready == 1'b1, "rst_mid_wait_fifo_empty", 32'(req_ready), 32'd1);

    // randomised traffic with random downstream backpressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      op  = 2'($urandom_range(0, 3));
      x   = 8'($urandom);
      y   = 8'($urandom);
      if (op == 2'b11 && $urandom_range(0, 2) == 0) y = 8'h00;
      lat = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, TO));
      push_req(op, x, y, lat);
    end
    drain("random_drain");
    chk(iss_q.size() == 0, "issue_queue_empty", 32'(iss_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
